uba_csr_responder: RTL and testbench



---
 rtl/uba_csr_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_uba_csr_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uba_csr_responder.sv
// uba_csr_responder
//   Target for KS10 backplane cycles that the arbiter has granted. It decodes
//   the arbiter address word and matches it against one Unibus-style
//   register bank. It then inserts WAITS wait states and returns a one-cycle
//   acknowledge together with the read data.
//
//   Bit numbering: the port descriptions use KS10 numbering, where bit 0 is
//   the MSB and bit 35 is the LSB. The vectors here are declared [35:0], so
//   KS10 bit b corresponds to index [35-b]:
//     READ  KS2  -> [33]   WRITE KS5 -> [30]   IO KS8 -> [27]
//     ctrl  KS14:17 -> [21:18]   address KS18:35 -> [17:0]
//     index KS33:34 -> [2:1]     odd byte KS35 -> [0]
//
//   Register map (index):
//     0 CSR      18-bit R/W in the low half, upper half reads 0
//     1,2 scratch 36-bit R/W
//     3 counter  36-bit, free-running, a write loads it
//
//   Optional build macro UBA_CSR_INTR_EN
//     Adds the devINTR output, which is IE (CSR 0o100) & DONE (CSR 0o200).
//     When the counter wraps, DONE is set in hardware.
//
//   Ports:
//     clk       system clock
//     rst_n     asynchronous active-low reset
//     busREQI   arbiter request, held until acknowledged
//     busACKO   one-cycle acknowledge
//     busADDRI  arbiter address word
//     busDATAI  write data
//     busDATAO  read data, zero whenever busACKO is low
//     devINTR   interrupt request (only with UBA_CSR_INTR_EN)
//
//   BASEADDR must be 8-byte aligned. Its low three bits are not compared.

module uba_csr_responder #(
    parameter logic [3:0]  CTRL     = 4'd3,
    parameter logic [17:0] BASEADDR = 18'o763100,
    parameter logic [3:0]  WAITS    = 4'd2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        busREQI,
    output logic        busACKO,
    input  logic [35:0] busADDRI,
    input  logic [35:0] busDATAI,
    output logic [35:0] busDATAO
`ifdef UBA_CSR_INTR_EN
    ,
    output logic        devINTR
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] IDX_CSR = 2'd0;
    localparam logic [1:0] IDX_SC1 = 2'd1;
    localparam logic [1:0] IDX_SC2 = 2'd2;
    localparam logic [1:0] IDX_CNT = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [1:0]  idx_q;
    logic        rd_q, wr_q;
    logic [35:0] wdata_q;

    logic [17:0] csr_q, csr_d;
    logic [35:0] scr1_q, scr2_q;
    logic [35:0] cnt_q, cnt_d;

    logic        hit;
    logic        capture;
    logic        commit;
    logic [35:0] rdata;

    // Address decode. The controller number, the bank base and an even byte
    // address must all match, and the cycle must be an IO cycle.
    assign hit = busADDRI[27]
               & (busADDRI[21:18] == CTRL)
               & (busADDRI[17:3] == BASEADDR[17:3])
               & ~busADDRI[0];

    assign capture = (state_q == S_IDLE) & busREQI & hit;
    assign commit  = (state_q == S_ACK) & wr_q;

    // These address-word bits carry nothing this target decodes.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{busADDRI[35:34], busADDRI[32:31],
                                busADDRI[29:28], busADDRI[26:22]};

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    wcnt_d  = WAITS;
                    state_d = (WAITS == 4'd0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q <= 4'd1) begin
                    wcnt_d  = '0;
                    state_d = S_ACK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // The request must drop before a new cycle can start, so a
                // request that is still held cannot trigger a second one.
                if (!busREQI) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // The request is captured once. busADDRI and busDATAI are ignored for
    // the rest of the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (capture) begin
            idx_q   <= busADDRI[2:1];
            rd_q    <= busADDRI[33];
            wr_q    <= busADDRI[30];
            wdata_q <= busDATAI;
        end
    end

    // The counter always increments. A write in the same cycle takes
    // priority over the increment.
    always_comb begin
        if (commit && (idx_q == IDX_CNT)) begin
            cnt_d = wdata_q;
        end else begin
            cnt_d = cnt_q + 36'd1;
        end
    end

`ifdef UBA_CSR_INTR_EN
    logic cnt_wrap;
    assign cnt_wrap = ~(commit && (idx_q == IDX_CNT)) & (&cnt_q);
`endif

    always_comb begin
        csr_d = csr_q;
        if (commit && (idx_q == IDX_CSR)) begin
            csr_d = wdata_q[17:0];
        end
`ifdef UBA_CSR_INTR_EN
        // A wrap in the same cycle as a software write leaves DONE set.
        if (cnt_wrap) begin
            csr_d[7] = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csr_q  <= '0;
            scr1_q <= '0;
            scr2_q <= '0;
            cnt_q  <= '0;
        end else begin
            csr_q <= csr_d;
            cnt_q <= cnt_d;
            if (commit && (idx_q == IDX_SC1)) begin
                scr1_q <= wdata_q;
            end
            if (commit && (idx_q == IDX_SC2)) begin
                scr2_q <= wdata_q;
            end
        end
    end

`ifdef UBA_CSR_INTR_EN
    logic intr_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intr_q <= 1'b0;
        end else begin
            intr_q <= csr_q[6] & csr_q[7];
        end
    end
    assign devINTR = intr_q;
`endif

    always_comb begin
        case (idx_q)
            IDX_CSR: rdata = {18'b0, csr_q};
            IDX_SC1: rdata = scr1_q;
            IDX_SC2: rdata = scr2_q;
            default: rdata = cnt_q;
        endcase
    end

    // The register values read here are the pre-write contents. A
    // read-modify-write therefore returns the old value.
    assign busACKO  = (state_q == S_ACK);
    assign busDATAO = (busACKO && rd_q) ? rdata : '0;

endmodule

// File: tb/tb_uba_csr_responder.sv
// Directed bench for uba_csr_responder with default parameters
// (CTRL=3, BASEADDR=763100, WAITS=2).
module tb_uba_csr_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busREQI;
    logic        busACKO;
    logic [35:0] busADDRI;
    logic [35:0] busDATAI;
    logic [35:0] busDATAO;
`ifdef UBA_CSR_INTR_EN
    logic        devINTR;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    int unsigned cyc = 0;
    logic [35:0] leak = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // busDATAO must be zero whenever busACKO is low
    always @(negedge clk) if (!busACKO) leak <= leak | busDATAO;

    uba_csr_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .busREQI  (busREQI),
        .busACKO  (busACKO),
        .busADDRI (busADDRI),
        .busDATAI (busDATAI),
        .busDATAO (busDATAO)
`ifdef UBA_CSR_INTR_EN
        ,
        .devINTR  (devINTR)
`endif
    );

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%o expected=%o", tag, obs, exp);
        end
    endtask

    function automatic logic [35:0] mk_addr(input logic rd, input logic wr, input logic io,
                                            input logic [3:0] ctl, input logic [17:0] ba);
        logic [35:0] a;
        a        = '0;
        a[33]    = rd;
        a[30]    = wr;
        a[27]    = io;
        a[21:18] = ctl;
        a[17:0]  = ba;
        return a;
    endfunction

    // Runs one full bus cycle. The address and data are scrambled after the
    // first edge. lat counts edges from the request to the ack (-1 if none).
    // at is the cycle number of the ack.
    task automatic bus_cycle(input logic rd, input logic wr, input logic [17:0] ba,
                             input logic [35:0] wd, output logic [35:0] rdat,
                             output int lat, output int unsigned at);
        busADDRI = mk_addr(rd, wr, 1'b1, 4'd3, ba);
        busDATAI = wd;
        busREQI  = 1'b1;
        rdat = '0;
        lat  = -1;
        at   = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); @(negedge clk);
            busADDRI = mk_addr(~rd, ~wr, 1'b1, 4'd3, 18'o763110);
            busDATAI = ~wd;
            if (busACKO) begin
                rdat = busDATAO;
                lat  = n;
                at   = cyc;
                break;
            end
        end
        @(posedge clk); @(negedge clk);
        chk("ack_width", {35'b0, busACKO}, 36'd0);
        busREQI = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic miss_probe(input logic [35:0] addr, output int acks, output logic [35:0] dor);
        busADDRI = addr;
        busREQI  = 1'b1;
        acks = 0;
        dor  = '0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (busACKO) acks++;
            dor = dor | busDATAO;
        end
        busREQI = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        logic [35:0] d;
        logic [35:0] dor;
        int lat, acks, first;
        int unsigned aw, ar, rel;

        rst_n    = 1'b0;
        busREQI  = 1'b0;
        busADDRI = '0;
        busDATAI = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_ack", {35'b0, busACKO}, 36'd0);
        chk("rst_data", busDATAO, 36'd0);
`ifdef UBA_CSR_INTR_EN
        chk("rst_intr", {35'b0, devINTR}, 36'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // scratch 1 write and readback
        bus_cycle(1'b0, 1'b1, 18'o763102, 36'o123456701234, d, lat, aw);
        chk("wr1_lat", 36'(lat), 36'd3);
        chk("wr1_data", d, 36'd0);
        bus_cycle(1'b1, 1'b0, 18'o763102, 36'o0, d, lat, ar);
        chk("rd1_lat", 36'(lat), 36'd3);
        chk("rd1_data", d, 36'o123456701234);

        // CSR upper half reads zero
        bus_cycle(1'b0, 1'b1, 18'o763100, 36'o777777777777, d, lat, aw);
        bus_cycle(1'b1, 1'b0, 18'o763100, 36'o0, d, lat, ar);
        chk("csr_rd", d, 36'o000000777777);

        // RMW on scratch 2
        bus_cycle(1'b0, 1'b1, 18'o763104, 36'o5, d, lat, aw);
        bus_cycle(1'b1, 1'b1, 18'o763104, 36'o7, d, lat, ar);
        chk("rmw_old", d, 36'o5);
        bus_cycle(1'b1, 1'b0, 18'o763104, 36'o0, d, lat, ar);
        chk("rmw_new", d, 36'o7);

        // neither flag: acked, data 0, nothing stored
        bus_cycle(1'b0, 1'b0, 18'o763102, 36'o1, d, lat, ar);
        chk("noop_lat", 36'(lat), 36'd3);
        chk("noop_data", d, 36'd0);
        bus_cycle(1'b1, 1'b0, 18'o763102, 36'o0, d, lat, ar);
        chk("noop_keep", d, 36'o123456701234);

        // non-hit requests
        miss_probe(mk_addr(1'b1, 1'b0, 1'b1, 4'd4, 18'o763102), acks, dor);
        chk("miss_ctrl_ack", 36'(acks), 36'd0);
        chk("miss_ctrl_data", dor, 36'd0);
        miss_probe(mk_addr(1'b1, 1'b0, 1'b1, 4'd3, 18'o763110), acks, dor);
        chk("miss_addr_ack", 36'(acks), 36'd0);
        chk("miss_addr_data", dor, 36'd0);
        miss_probe(mk_addr(1'b1, 1'b0, 1'b1, 4'd3, 18'o763103), acks, dor);
        chk("miss_odd_ack", 36'(acks), 36'd0);
        miss_probe(mk_addr(1'b1, 1'b0, 1'b0, 4'd3, 18'o763102), acks, dor);
        chk("miss_io_ack", 36'(acks), 36'd0);

        // held request gives one ack; drop one cycle and re-request
        busADDRI = mk_addr(1'b1, 1'b0, 1'b1, 4'd3, 18'o763104);
        busREQI  = 1'b1;
        acks  = 0;
        first = -1;
        for (int n = 1; n <= 14; n++) begin
            @(posedge clk); @(negedge clk);
            if (busACKO) begin
                acks++;
                if (first < 0) first = n;
            end
        end
        chk("hold_acks", 36'(acks), 36'd1);
        chk("hold_first", 36'(first), 36'd3);
        busREQI = 1'b0;
        @(posedge clk); @(negedge clk);
        busREQI = 1'b1;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); @(negedge clk);
            if (busACKO) begin
                lat = n;
                break;
            end
        end
        chk("rereq_lat", 36'(lat), 36'd3);
        busREQI = 1'b0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);

        // counter: the write takes priority over the increment, then counting resumes
        bus_cycle(1'b0, 1'b1, 18'o763106, 36'o1000, d, lat, aw);
        bus_cycle(1'b1, 1'b0, 18'o763106, 36'o0, d, lat, ar);
        chk("cnt_load", d, 36'o1000 + 36'(ar - aw - 1));
        bus_cycle(1'b0, 1'b1, 18'o763106, 36'o777777777777, d, lat, aw);
        bus_cycle(1'b1, 1'b0, 18'o763106, 36'o0, d, lat, ar);
        chk("cnt_wrap", d, 36'(ar - aw - 2));

        // reset during WAIT
        busADDRI = mk_addr(1'b1, 1'b0, 1'b1, 4'd3, 18'o763102);
        busREQI  = 1'b1;
        @(posedge clk); @(negedge clk);
        rst_n   = 1'b0;
        busREQI = 1'b0;
        acks = 0;
        dor  = '0;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); @(negedge clk);
            if (busACKO) acks++;
            dor = dor | busDATAO;
        end
        rst_n = 1'b1;
        rel   = cyc;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); @(negedge clk);
            if (busACKO) acks++;
        end
        chk("rstwait_acks", 36'(acks), 36'd0);
        chk("rstwait_data", dor, 36'd0);
        bus_cycle(1'b1, 1'b0, 18'o763102, 36'o0, d, lat, ar);
        chk("rst_sc1", d, 36'd0);
        bus_cycle(1'b1, 1'b0, 18'o763104, 36'o0, d, lat, ar);
        chk("rst_sc2", d, 36'd0);
        bus_cycle(1'b1, 1'b0, 18'o763100, 36'o0, d, lat, ar);
        chk("rst_csr", d, 36'd0);
        bus_cycle(1'b1, 1'b0, 18'o763106, 36'o0, d, lat, ar);
        chk("rst_cnt", d, 36'(ar - rel));

`ifdef UBA_CSR_INTR_EN
        // IE first, then load the counter two counts before the wrap
        bus_cycle(1'b0, 1'b1, 18'o763100, 36'o100, d, lat, aw);
        chk("intr_ie_only", {35'b0, devINTR}, 36'd0);
        bus_cycle(1'b0, 1'b1, 18'o763106, 36'o777777777776, d, lat, aw);
        @(posedge clk); @(negedge clk);
        chk("intr_pre", {35'b0, devINTR}, 36'd0);
        @(posedge clk); @(negedge clk);
        chk("intr_set", {35'b0, devINTR}, 36'd1);
        bus_cycle(1'b1, 1'b0, 18'o763100, 36'o0, d, lat, ar);
        chk("intr_csr", d, 36'o300);
        bus_cycle(1'b0, 1'b1, 18'o763100, 36'o0, d, lat, aw);
        @(posedge clk); @(negedge clk);
        chk("intr_clr", {35'b0, devINTR}, 36'd0);
`endif

        chk("idle_data_zero", leak, 36'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
